// File: rtl/vga_pix_timing_ctrl.sv
// vga_pix_timing_ctrl
//   Pixel-draw sequencer. Walks x/y over the full raster (active + porches +
//   sync), produces hs/vs/de for the pixel bundle, and issues one snapshot
//   request per frame so the values drawn stay frozen across a visible frame.
//   Stopping always finishes the frame in progress before going idle.
// Ports
//   clk_25_i       pixel clock
//   rst_n_i        asynchronous active-low reset
//   en_i           run request (level)
//   x_o, y_o       current pixel coordinate
//   hs_o, vs_o     syncs, active level set by HS_POL / VS_POL
//   de_o           active-video flag
//   frame_start_o  1-cycle pulse with pixel (0,0)
//   snap_req_o     snapshot request to the value sources
//   snap_ack_i     snapshot taken
//   snap_miss_o    1-cycle pulse when a request expired unacknowledged
//   miss_cnt_o     saturating miss count
module vga_pix_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_X_W  = 12,
  parameter int PIX_Y_W  = 12
) (
  input  logic               clk_25_i,
  input  logic               rst_n_i,
  input  logic               en_i,
  output logic [PIX_X_W-1:0] x_o,
  output logic [PIX_Y_W-1:0] y_o,
  output logic               hs_o,
  output logic               vs_o,
  output logic               de_o,
  output logic               frame_start_o,
  output logic               snap_req_o,
  input  logic               snap_ack_i,
  output logic               snap_miss_o,
  output logic [7:0]         miss_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [PIX_X_W-1:0] X_LAST = PIX_X_W'(H_TOTAL - 1);
  localparam logic [PIX_X_W-1:0] X_ACT  = PIX_X_W'(H_ACTIVE);
  localparam logic [PIX_X_W-1:0] X_HS0  = PIX_X_W'(H_ACTIVE + H_FP);
  localparam logic [PIX_X_W-1:0] X_HS1  = PIX_X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [PIX_Y_W-1:0] Y_LAST = PIX_Y_W'(V_TOTAL - 1);
  localparam logic [PIX_Y_W-1:0] Y_ACT  = PIX_Y_W'(V_ACTIVE);
  localparam logic [PIX_Y_W-1:0] Y_VS0  = PIX_Y_W'(V_ACTIVE + V_FP);
  localparam logic [PIX_Y_W-1:0] Y_VS1  = PIX_Y_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [PIX_X_W-1:0]   x_q, x_d;
  logic [PIX_Y_W-1:0]   y_q, y_d;
  logic                 hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
  logic                 req_q, req_d, miss_q, miss_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 at_last, active, origin;

  assign at_last = (x_q == X_LAST) && (y_q == Y_LAST);

  // A stop request seen on the very last pixel goes straight to idle, so a
  // stop never starts another frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (en_i) state_d = S_RUN;
      S_RUN:   if (!en_i) state_d = at_last ? S_IDLE : S_DRAIN;
      S_DRAIN: if (en_i) state_d = S_RUN;
               else if (at_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next pixel coordinate and registered, so
  // x/y/hs/vs/de always describe the same pixel.
  always_comb begin
    x_d = '0;
    y_d = '0;
    if (state_q != S_IDLE) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + PIX_Y_W'(1);
      end else begin
        x_d = x_q + PIX_X_W'(1);
        y_d = y_q;
      end
    end
    active = (state_d != S_IDLE);
    origin = (x_d == '0) && (y_d == '0);
    de_d   = active && (x_d < X_ACT) && (y_d < Y_ACT);
    hs_d   = (active && (x_d >= X_HS0) && (x_d < X_HS1)) ? HS_POL : !HS_POL;
    vs_d   = (active && (y_d >= Y_VS0) && (y_d < Y_VS1)) ? VS_POL : !VS_POL;
    fs_d   = active && origin;

    // Ack takes priority over expiry: an ack sampled on the last pixel of
    // the frame is on time.
    req_d  = req_q;
    miss_d = 1'b0;
    if (!active) begin
      req_d = 1'b0;
    end else if (req_q && snap_ack_i) begin
      req_d = 1'b0;
    end else if (req_q && origin) begin
      req_d  = 1'b0;
      miss_d = 1'b1;
    end else if ((x_d == '0) && (y_d == Y_ACT)) begin
      req_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (miss_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk_25_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= !HS_POL;
      vs_q    <= !VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      req_q   <= 1'b0;
      miss_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      req_q   <= req_d;
      miss_q  <= miss_d;
      cnt_q   <= cnt_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign de_o          = de_q;
  assign frame_start_o = fs_q;
  assign snap_req_o    = req_q;
  assign snap_miss_o   = miss_q;
  assign miss_cnt_o    = cnt_q;

endmodule
